// File: rtl/bagging_pkg.sv
// Shared types and constants for the bagged-ensemble vote stage.
package bagging_pkg;

  // Learner core prediction encoding: 2-bit signed, 2'b10 carries no vote.
  typedef logic [1:0] pred_t;

  localparam pred_t PRED_POS  = 2'b01;
  localparam pred_t PRED_NEG  = 2'b11;
  localparam pred_t PRED_ZERO = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VOTE    = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  // Registered ensemble result presented downstream.
  typedef struct packed {
    pred_t pred;
    logic  timed_out;
    logic  no_quorum;
  } vote_out_t;

  function automatic logic pred_is_pos(input pred_t p);
    return p == PRED_POS;
  endfunction

  function automatic logic pred_is_neg(input pred_t p);
    return p == PRED_NEG;
  endfunction

endpackage

// File: rtl/bagging_vote_aggregator_vote_counter.sv
// Combinational +1 / -1 tally over the selected learner entries.
module vote_counter
  import bagging_pkg::*;
#(
  parameter int unsigned N_LRN = 3,
  parameter int unsigned CNT_W = 2
) (
  input  logic [2*N_LRN-1:0] results,
  input  logic [N_LRN-1:0]   mask,
  output logic [CNT_W-1:0]   pos_c,
  output logic [CNT_W-1:0]   neg_c
);

  // Count positive and negative votes among masked-in entries.
  always_comb begin
    pos_c = '0;
    neg_c = '0;
    for (int i = 0; i < N_LRN; i++) begin
      if (mask[i]) begin
        if (pred_is_pos(results[2*i +: 2])) begin
          pos_c = pos_c + CNT_W'(1);
        end else if (pred_is_neg(results[2*i +: 2])) begin
          neg_c = neg_c + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/bagging_vote_aggregator.sv
// Majority-vote combiner for N bagged learners with timeout and valid/ready output.
module bagging_vote_aggregator
  import bagging_pkg::*;
#(
  parameter int unsigned N_LRN   = 3,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_LRN-1:0]   lrn_mask,
  input  logic [2*N_LRN-1:0] lrn_result,
  input  logic [N_LRN-1:0]   lrn_ready,
  input  logic               out_ready,
  output logic [1:0]         total_predict,
  output logic               total_valid,
  output logic               timed_out,
  output logic               no_quorum,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(N_LRN + 1);
  localparam int unsigned CMP_W = CNT_W + 1;
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e               state_q, state_d;
  logic [N_LRN-1:0]     act_q, act_d;
  logic [N_LRN-1:0]     got_q, got_d;
  logic [2*N_LRN-1:0]   res_q, res_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 to_q, to_d;
  vote_out_t            out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  logic [CNT_W-1:0]     pos_c, neg_c, n_act_c;
  logic [CMP_W-1:0]     pos2_c, neg2_c, n_ext_c;
  vote_out_t            vote_c;

  // Tally only entries that were actually captured this round.
  vote_counter #(
    .N_LRN (N_LRN),
    .CNT_W (CNT_W)
  ) u_vote_counter (
    .results (res_q),
    .mask    (got_q & act_q),
    .pos_c   (pos_c),
    .neg_c   (neg_c)
  );

  // Majority decision; missing learners still count toward the electorate.
  always_comb begin
    n_act_c = '0;
    for (int i = 0; i < N_LRN; i++) begin
      n_act_c = n_act_c + CNT_W'(act_q[i]);
    end
    pos2_c = {pos_c, 1'b0};
    neg2_c = {neg_c, 1'b0};
    n_ext_c = CMP_W'(n_act_c);
    vote_c.timed_out = to_q;
    vote_c.pred      = PRED_ZERO;
    vote_c.no_quorum = 1'b1;
    if (n_act_c != '0) begin
      if (neg2_c > n_ext_c) begin
        vote_c.pred      = PRED_NEG;
        vote_c.no_quorum = 1'b0;
      end else if (pos2_c > n_ext_c) begin
        vote_c.pred      = PRED_POS;
        vote_c.no_quorum = 1'b0;
      end
    end
  end

  // Round sequencing, capture of learner results and output staging.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    got_d   = got_q;
    res_d   = res_q;
    timer_d = timer_q;
    to_d    = to_q;
    out_d   = out_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          act_d   = lrn_mask;
          got_d   = '0;
          timer_d = '0;
          to_d    = 1'b0;
          state_d = (lrn_mask == '0) ? ST_VOTE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        for (int i = 0; i < N_LRN; i++) begin
          if (act_q[i] && lrn_ready[i] && !got_q[i]) begin
            res_d[2*i +: 2] = lrn_result[2*i +: 2];
            got_d[i]        = 1'b1;
          end
        end
        timer_d = timer_q + TMR_W'(1);
        if ((got_d | ~act_q) == '1) begin
          state_d = ST_VOTE;
        end else if ((TIMEOUT != 0) && (timer_q == TMR_W'(TIMEOUT - 1))) begin
          state_d = ST_VOTE;
          to_d    = 1'b1;
        end
      end
      ST_VOTE: begin
        out_d   = vote_c;
        valid_d = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      act_q   <= '0;
      got_q   <= '0;
      res_q   <= '0;
      timer_q <= '0;
      to_q    <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      got_q   <= got_d;
      res_q   <= res_d;
      timer_q <= timer_d;
      to_q    <= to_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign total_predict = out_q.pred;
  assign timed_out     = out_q.timed_out;
  assign no_quorum     = out_q.no_quorum;
  assign total_valid   = valid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_bagging_vote_aggregator.sv
// Directed bench for bagging_vote_aggregator with a round-level reference model.
module tb_bagging_vote_aggregator;

  localparam int TMO = 8;
  localparam int NL  = 5;

  logic          clk;
  logic          rst;
  logic          en;
  logic [NL-1:0] lrn_mask;
  logic [2*NL-1:0] lrn_result;
  logic [NL-1:0] lrn_ready;
  logic          out_ready;
  logic [1:0]    total_predict;
  logic          total_valid;
  logic          timed_out;
  logic          no_quorum;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  // Expected round behaviour, published by the driver for the compare process.
  bit    in_round = 0;
  int    off = 0;
  int    m_pred, m_to, m_nq, m_lat, m_xfer;
  string cur_tag = "init";

  bagging_vote_aggregator #(
    .N_LRN   (NL),
    .TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .lrn_mask      (lrn_mask),
    .lrn_result    (lrn_result),
    .lrn_ready     (lrn_ready),
    .out_ready     (out_ready),
    .total_predict (total_predict),
    .total_valid   (total_valid),
    .timed_out     (timed_out),
    .no_quorum     (no_quorum),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare DUT against the model on every cycle of a round.
  always @(negedge clk) begin
    if (in_round) begin
      chk({cur_tag, "_busy"}, int'(busy), int'(off >= 1 && off <= m_xfer));
      chk({cur_tag, "_valid"}, int'(total_valid), int'(off >= m_lat && off <= m_xfer));
      if (off >= m_lat && off <= m_xfer) begin
        chk({cur_tag, "_predict"}, int'(total_predict), m_pred);
        chk({cur_tag, "_timed_out"}, int'(timed_out), m_to);
        chk({cur_tag, "_no_quorum"}, int'(no_quorum), m_nq);
      end
    end
  end

  // roff: 4-bit first-ready offset per learner (0 = never); offset k is k cycles after en.
  task automatic run_round(input string tag, input logic [NL-1:0] mask,
                           input logic [2*NL-1:0] res, input logic [4*NL-1:0] roff,
                           input logic [NL-1:0] hold, input int bp, input bit spam,
                           input int lit_pred, input int lit_lat, input int lit_to,
                           input int lit_nq);
    int n, pos, neg, last, o;
    bit all_in;
    n = 0; pos = 0; neg = 0; last = 0; all_in = 1;
    for (int i = 0; i < NL; i++) begin
      if (mask[i]) begin
        n++;
        o = int'(roff[4*i +: 4]);
        if (o != 0 && o <= TMO) begin
          if (res[2*i +: 2] == 2'b01) pos++;
          else if (res[2*i +: 2] == 2'b11) neg++;
          if (o > last) last = o;
        end else begin
          all_in = 0;
        end
      end
    end
    m_nq = 0;
    if (n == 0) begin m_pred = 0; m_nq = 1; end
    else if (2 * neg > n) m_pred = 3;
    else if (2 * pos > n) m_pred = 1;
    else begin m_pred = 0; m_nq = 1; end
    m_to   = (n != 0 && !all_in) ? 1 : 0;
    m_lat  = (n == 0) ? 2 : (all_in ? last + 2 : TMO + 2);
    m_xfer = m_lat + bp;
    cur_tag = tag;
    chk({tag, "_model_pred"}, m_pred, lit_pred);
    chk({tag, "_model_lat"}, m_lat, lit_lat);
    chk({tag, "_model_to"}, m_to, lit_to);
    chk({tag, "_model_nq"}, m_nq, lit_nq);
    for (int k = 0; k <= m_xfer + 1; k++) begin
      @(posedge clk);
      #1;
      off       = k;
      in_round  = 1;
      en        = (k == 0) || (spam && k <= m_xfer);
      lrn_mask  = (k == 0 || !spam) ? mask : ~mask;
      out_ready = (k == m_xfer);
      for (int i = 0; i < NL; i++) begin
        o = int'(roff[4*i +: 4]);
        lrn_ready[i] = (o != 0) && (k == o || (hold[i] && k > o));
        lrn_result[2*i +: 2] = (o != 0 && k > o) ? ~res[2*i +: 2] : res[2*i +: 2];
      end
    end
    @(posedge clk);
    #1;
    in_round  = 0;
    en        = 0;
    lrn_ready = '0;
    out_ready = 0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_predict"}, int'(total_predict), 0);
    chk({tag, "_valid"}, int'(total_valid), 0);
    chk({tag, "_timed_out"}, int'(timed_out), 0);
    chk({tag, "_no_quorum"}, int'(no_quorum), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 0; en = 0; lrn_mask = '0; lrn_result = '0; lrn_ready = '0; out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk);
    #1 rst = 1;

    // three learners, 2 of 3 positive, all ready the cycle after en
    run_round("maj3", 5'b00111, 10'b00_00_11_01_01, 20'h00111, 5'b00000, 0, 0, 1, 3, 0, 0);
    // five learners, staggered readies, backpressure with en/mask spam
    run_round("stag5", 5'b11111, 10'b00_01_11_11_11, 20'h24321, 5'b00101, 5, 1, 3, 6, 0, 0);
    // four learners tied, masked learner 4 also pulses
    run_round("tie4", 5'b01111, 10'b11_11_11_01_01, 20'h11111, 5'b00000, 0, 0, 0, 3, 0, 1);
    // mask 101, masked learner 1 pulses ready with -1
    run_round("mask101", 5'b00101, 10'b00_00_01_11_01, 20'h00321, 5'b00000, 1, 0, 1, 5, 0, 0);
    // timeout with only learner 0 reporting
    run_round("tmo", 5'b00111, 10'b00_00_11_11_01, 20'h00002, 5'b00000, 0, 0, 0, 10, 1, 1);
    // learner 1 reports after the timeout window
    run_round("late", 5'b00011, 10'b00_00_00_11_01, 20'h00091, 5'b00000, 0, 0, 0, 10, 1, 1);
    // sole learner completes on the last timer cycle: completion, not timeout
    run_round("edge8", 5'b00001, 10'b00_00_00_00_11, 20'h00008, 5'b00000, 0, 0, 3, 10, 0, 0);
    // all-zero mask
    run_round("zero", 5'b00000, 10'b11_11_11_11_11, 20'h11111, 5'b00000, 0, 0, 0, 2, 0, 1);
    // 2'b10 casts no vote
    run_round("inv", 5'b00111, 10'b00_00_01_10_01, 20'h00111, 5'b00000, 0, 0, 1, 3, 0, 0);
    // held readies with changing results: first capture wins
    run_round("held", 5'b11111, 10'b11_11_01_01_01, 20'h11111, 5'b11111, 2, 0, 1, 3, 0, 0);

    // reset mid-COLLECT
    cur_tag = "rstmid";
    @(posedge clk); #1;
    en = 1; lrn_mask = 5'b00111; lrn_result = 10'b00_00_11_11_11;
    @(posedge clk); #1;
    en = 0; lrn_ready = 5'b00011;
    @(posedge clk); #1;
    lrn_ready = '0;
    @(negedge clk);
    chk("rstmid_busy_before", int'(busy), 1);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk_idle_outputs("rstmid");
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk_idle_outputs("rstmid_after");
    run_round("postrst", 5'b00111, 10'b00_00_00_00_01, 20'h00100, 5'b00000, 0, 0, 0, 10, 1, 1);
    run_round("postrst2", 5'b00111, 10'b00_00_00_01_01, 20'h00111, 5'b00000, 0, 0, 1, 3, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bagging_vote_aggregator.md
# bagging_vote_aggregator

Parametrised majority-vote combiner for an ensemble of N bagged learners, the successor to the fixed three-learner vote stage. Each learner's 2-bit signed prediction is captured whenever that learner flags ready, and learners may finish on different cycles. Masked-out learners are excluded from the vote. A timeout closes a round in which some learner never reports. The registered ensemble prediction is presented on a valid/ready output handshake to the downstream classifier-control logic.

## Interface
- N_LRN, 3, number of learner channels (1..16)
- TIMEOUT, 64, max cycles in COLLECT before forced vote; 0 disables the timeout
- CNT_W, $clog2(N_LRN+1), vote-counter width (derived, not overridden)
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  start a round; sampled in IDLE only
- lrn_mask  in  N_LRN  per-learner participation; sampled into a register at round start
- lrn_result  in  2*N_LRN  packed signed predictions; learner i at [2i+1:2i]; 2'b01=+1, 2'b11=-1, 2'b00=0, 2'b10 treated as 0
- lrn_ready  in  N_LRN  learner i result valid this cycle
- out_ready  in  1  downstream accepts prediction
- total_predict  out  2  signed ensemble prediction
- total_valid  out  1  prediction held valid until accepted
- timed_out  out  1  qualifies total_predict; round closed by timeout
- no_quorum  out  1  qualifies total_predict; no strict majority, or zero active learners
- busy  out  1  state != IDLE

## Operation
- States: IDLE, COLLECT, VOTE, HOLD.
- IDLE: en=1 -> latch lrn_mask into act; clear got bitmap and timer; go to COLLECT.
- IDLE with act=0 (all-zero mask): go straight to VOTE.
- COLLECT: for each i with act[i] & lrn_ready[i] & !got[i], capture lrn_result[i] and set got[i].
  - First capture wins; later pulses from the same learner are ignored.
  - lrn_ready from masked learners is ignored.
- COLLECT exit: (got|~act)==all-ones -> VOTE. Else timer==TIMEOUT-1 (TIMEOUT>0) -> VOTE with timeout flag set.
- VOTE: over captured entries only, pos = count of +1, neg = count of -1, n = popcount(act).
  - neg*2 > n -> 2'b11.
  - Else pos*2 > n -> 2'b01.
  - Else 2'b00 with no_quorum=1.
  - n=0 -> 2'b00 with no_quorum=1.
  - Missing (timed-out) learners count toward n but cast no vote.
  - Counters are CNT_W bits; comparisons use CNT_W+1 bits, so there is no overflow.
- VOTE registers the outputs, asserts total_valid, and goes to HOLD.
- HOLD: outputs stable while total_valid & !out_ready. On out_ready=1, clear total_valid and go to IDLE.
- en outside IDLE is ignored; rounds never overlap.
- Reset: IDLE; total_predict=0, total_valid=0, timed_out=0, no_quorum=0, busy=0; got, act and timer cleared.
- Reset mid-round discards all captured results. The first post-reset round starts on the first en after rst deasserts.

## Timing
- en at cycle t -> busy=1 from t+1.
- Last required lrn_ready at cycle c -> VOTE at c+1 -> total_valid=1 from c+2.
- All learners ready on the cycle after en: total_valid at t+3.
- Timeout: total_valid at t+TIMEOUT+2.
- Transfer completes on the cycle with total_valid & out_ready. busy=0 the next cycle. Earliest next en accepted one cycle after that.
- lrn_ready may be a single-cycle pulse or a held level; both are captured once.
- Multiple learners reporting on the same cycle are all captured that cycle.

## Structure
- Shared package bagging_pkg: PRED_POS=2'b01, PRED_NEG=2'b11, PRED_ZERO=2'b00, and the state enum.
- The existing result encoding for the learner cores moves into bagging_pkg as well.
- One sub-module, vote_counter: combinational popcount of +1/-1 over N_LRN masked entries, returning pos/neg.

## Test plan
- N_LRN=3, mask=111, results +1,+1,-1, all ready on cycle t+1 -> total_predict=01, no_quorum=0, total_valid at t+3.
- N_LRN=5, mask=11111, results -1,-1,-1,+1,0, readies staggered over 4 cycles -> predict 11, valid 2 cycles after the last ready.
- N_LRN=4, results +1,+1,-1,-1 -> predict 00, no_quorum=1.
- Mask=101 (N_LRN=3), learner 1 never ready, results +1,x,+1 -> predict 01. A learner-1 ready pulse has no effect.
- TIMEOUT=8, mask=111, only learner 0 reports +1 -> valid at t+10, timed_out=1, predict 00 (1*2 > 3 false), no_quorum=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles -> outputs stable, en ignored.
  - Assert rst mid-COLLECT -> all outputs 0; the next round is unaffected by earlier captures.
